vector_control_fsm: RTL and testbench

VECTOR_CONTROL_FSM -- requirements
Module: vector_control_fsm

---
 rtl/vector_control_fsm.sv | 118 +++++++++++
 tb/tb_vector_control_fsm.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vector_control_fsm.sv
// Control FSM for vector load/store and data-processing instructions.
// Each instruction is accepted in IDLE, routed from DECODE, then walks one memory access per lane.
module vector_control_fsm #(
    parameter int LANES   = 4,
    parameter int FUNCT_W = 2,
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [1:0]         Op,
    input  logic [FUNCT_W-1:0] Funct,
    output logic               mem_req,
    input  logic               mem_ack,
    output logic [LIDX_W-1:0]  lane_idx,
    output logic               RegW,
    output logic               MemW,
    output logic               MemToReg,
    output logic               ALUSrc,
    output logic               ALUOp,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic               done,
    output logic               illegal,
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, DONE} state_t;

    // Control words packed as {MemToReg,MemW,ALUSrc,ImmSrc,RegW,RegSrc,ALUOp}
    localparam logic [8:0] CW_DP_REG = 9'b0_0_0_11_1_00_1;
    localparam logic [8:0] CW_DP_IMM = 9'b0_0_1_00_1_00_1;
    localparam logic [8:0] CW_STRV   = 9'b0_1_1_01_0_10_0;
    localparam logic [8:0] CW_LDRV   = 9'b1_0_0_01_1_00_0;
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              load_q, load_d;
    logic [LIDX_W-1:0] lane_q, lane_d;
    logic [8:0]        ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            load_q  <= 1'b0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            load_q  <= load_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        load_d      = load_q;
        lane_d      = lane_q;
        instr_ready = 1'b0;
        busy        = 1'b1;
        mem_req     = 1'b0;
        lane_idx    = '0;
        done        = 1'b0;
        illegal     = 1'b0;
        ctrl        = '0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    op_d    = Op;
                    load_d  = Funct[0];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (op_q)
                    2'b00, 2'b01: state_d = EXEC;
                    2'b10: begin
                        lane_d  = '0;
                        state_d = MEM;
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
            EXEC: begin
                ctrl    = op_q[0] ? CW_DP_IMM : CW_DP_REG;
                state_d = DONE;
            end
            MEM: begin
                mem_req  = 1'b1;
                lane_idx = lane_q;
                ctrl     = load_q ? CW_LDRV : CW_STRV;
                // Loads write the register file once per acknowledged lane only
                ctrl[3]  = load_q && mem_ack;
                if (mem_ack) begin
                    if (lane_q == LAST_LANE) state_d = DONE;
                    else                     lane_d  = lane_q + LIDX_W'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign {MemToReg, MemW, ALUSrc, ImmSrc, RegW, RegSrc, ALUOp} = ctrl;

endmodule

// File: tb/tb_vector_control_fsm.sv
// Randomized bench for vector_control_fsm against a per-instruction schedule model.
module tb_vector_control_fsm;

    localparam int LANES = 4;
    localparam int FW    = 2;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [1:0]    Op = '0;
    logic [FW-1:0] Funct = '0;
    logic          mem_req;
    logic          mem_ack = 1'b0;
    logic [LW-1:0] lane_idx;
    logic          RegW, MemW, MemToReg, ALUSrc, ALUOp;
    logic [1:0]    ImmSrc, RegSrc;
    logic          done, illegal, busy;

    vector_control_fsm #(.LANES(LANES), .FUNCT_W(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .Op(Op), .Funct(Funct),
        .mem_req(mem_req), .mem_ack(mem_ack), .lane_idx(lane_idx),
        .RegW(RegW), .MemW(MemW), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .done(done), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // One entry per expected busy cycle; memory entries persist until acknowledged
    typedef struct packed {
        logic [8:0]    ctrl;
        logic          mem;
        logic          load;
        logic [LW-1:0] lane;
        logic          done;
        logic          ill;
    } step_t;

    step_t sched[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic step_t mk(input logic [8:0] c, input logic m, input logic ld,
                                 input int ln, input logic d, input logic il);
        step_t s;
        s.ctrl = c; s.mem = m; s.load = ld; s.lane = LW'(ln); s.done = d; s.ill = il;
        return s;
    endfunction

    task automatic schedule(input logic [1:0] op, input logic f0);
        sched.push_back(mk(9'h0, 1'b0, 1'b0, 0, 1'b0, op == 2'b11));
        if (op == 2'b00 || op == 2'b01) begin
            sched.push_back(mk(op[0] ? 9'b0_0_1_00_1_00_1 : 9'b0_0_0_11_1_00_1, 0, 0, 0, 0, 0));
            sched.push_back(mk(9'h0, 1'b0, 1'b0, 0, 1'b1, 1'b0));
        end else if (op == 2'b10) begin
            for (int i = 0; i < LANES; i++)
                sched.push_back(mk(f0 ? 9'b1_0_0_01_1_00_0 : 9'b0_1_1_01_0_10_0, 1'b1, f0, i, 1'b0, 1'b0));
            sched.push_back(mk(9'h0, 1'b0, 1'b0, 0, 1'b1, 1'b0));
        end
    endtask

    task automatic cycle(input logic v, input logic [1:0] op, input logic [FW-1:0] f, input logic ack);
        logic [8:0]    exp_ctrl;
        logic [8:0]    obs_ctrl;
        logic          exp_mem, exp_done, exp_ill, exp_idle;
        logic [LW-1:0] exp_lane;
        @(negedge clk);
        instr_valid = v; Op = op; Funct = f; mem_ack = ack;
        #1;
        exp_idle = (sched.size() == 0);
        exp_ctrl = '0; exp_mem = 0; exp_lane = '0; exp_done = 0; exp_ill = 0;
        if (!exp_idle) begin
            exp_ctrl = sched[0].ctrl;
            exp_mem  = sched[0].mem;
            exp_lane = sched[0].lane;
            exp_done = sched[0].done;
            exp_ill  = sched[0].ill;
            if (sched[0].mem) exp_ctrl[3] = sched[0].load && ack;
        end
        obs_ctrl = {MemToReg, MemW, ALUSrc, ImmSrc, RegW, RegSrc, ALUOp};
        check("ctrl", 32'(obs_ctrl), 32'(exp_ctrl));
        check("mem_req", 32'(mem_req), 32'(exp_mem));
        check("lane_idx", 32'(lane_idx), 32'(exp_lane));
        check("done", 32'(done), 32'(exp_done));
        check("illegal", 32'(illegal), 32'(exp_ill));
        check("instr_ready", 32'(instr_ready), 32'(exp_idle));
        check("busy", 32'(busy), 32'(!exp_idle));
        @(posedge clk);
        if (sched.size() == 0) begin
            if (v) schedule(op, f[0]);
        end else if (!(sched[0].mem && !ack)) begin
            void'(sched.pop_front());
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        instr_valid = 1'b0; mem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_lane", 32'(lane_idx), 32'd0);
        sched.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        check("init_ready", 32'(instr_ready), 32'd1);
        check("init_busy", 32'(busy), 32'd0);
        check("init_mem_req", 32'(mem_req), 32'd0);
        check("init_ctrl", 32'({MemToReg, MemW, ALUSrc, ImmSrc, RegW, RegSrc, ALUOp}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // DP register, DP immediate
        cycle(1, 2'b00, 2'b00, 0);
        for (int i = 0; i < 4; i++) cycle(0, 2'b00, 2'b00, 0);
        cycle(1, 2'b01, 2'b00, 0);
        for (int i = 0; i < 4; i++) cycle(0, 2'b00, 2'b00, 0);

        // LDRV with ack tied high
        cycle(1, 2'b10, 2'b01, 1);
        for (int i = 0; i < LANES + 3; i++) cycle(0, 2'b00, 2'b00, 1);

        // STRV stalled five cycles on lane 2
        cycle(1, 2'b10, 2'b00, 1);
        cycle(0, 2'b00, 2'b00, 1);
        cycle(0, 2'b00, 2'b00, 1);
        cycle(0, 2'b00, 2'b00, 1);
        for (int i = 0; i < 5; i++) cycle(0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 4; i++) cycle(0, 2'b00, 2'b00, 1);

        // Undefined Op
        cycle(1, 2'b11, 2'b00, 1);
        for (int i = 0; i < 3; i++) cycle(0, 2'b00, 2'b00, 1);

        // valid held high with Op changing while busy
        for (int i = 0; i < 16; i++) cycle(1, 2'($urandom), FW'($urandom), 1);

        // Reset while on lane 1, then a fresh LDRV
        for (int i = 0; i < 8; i++) cycle(0, 2'b00, 2'b00, 1);
        cycle(1, 2'b10, 2'b01, 0);
        cycle(0, 2'b00, 2'b00, 0);
        cycle(0, 2'b00, 2'b00, 1);
        async_reset();
        cycle(1, 2'b10, 2'b01, 1);
        for (int i = 0; i < LANES + 3; i++) cycle(0, 2'b00, 2'b00, 1);

        for (int i = 0; i < 1500; i++)
            cycle(($urandom % 3) != 0, 2'($urandom), FW'($urandom), ($urandom % 4) != 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
